mux_n_to_1_pipe: RTL and testbench
==================================

Name: mux_n_to_1_pipe

Overview:
- Parametrised N-way, W-bit registered selector with a valid/ready handshake and a 1-entry skid buffer.
- Generalises the combinational 4:1 word mux to any input count and width.
- Adds one-cycle pipelining, backpressure and flush.
- Used in the datapath wherever a selected operand must cross a pipeline-register boundary, e.g. forwarding select into the EX/MEM stage or writeback source select under stall.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- NUM_INPUTS, 4, number of selectable inputs (>=2).
- SEL_W, $clog2(NUM_INPUTS), select width. Derived; do not override.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_INPUTS*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  index of the input to capture.
- in_valid  input  1  upstream offers {in_data[in_sel], in_sel}.
- in_ready  output  1  block can accept this cycle.
- flush  input  1  synchronous discard of all held words.
- out_data  output  WIDTH  registered selected word.
- out_sel  output  SEL_W  index that produced out_data.
- out_valid  output  1  out_data/out_sel valid.
- out_ready  input  1  downstream accepts.

Behaviour:
- Selection is combinational: word = in_data[in_sel*WIDTH +: WIDTH] when in_sel < NUM_INPUTS, else all-zero. The all-zero case applies to non-power-of-2 NUM_INPUTS.
- Transfer rules: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: output register (OR) plus skid register (SK), each holding {data, sel, valid}.
- in_ready = !SK.valid. It is a pure function of state, with no combinational path from out_ready.
- Latency: an accepted word appears on out_data the next cycle when OR is empty or being popped.
- On accept:
  - If OR empty or pop: OR <= word.
  - Else: SK <= word, and in_ready drops next cycle.
- On pop with SK valid: OR <= SK and SK clears. Accept is impossible in the same cycle because in_ready=0.
- On pop with nothing new: OR.valid <= 0. Data/sel registers keep their last value; they are don't-care when invalid.
- Simultaneous accept and pop, SK empty: OR takes the new word, no bubble. Full throughput is 1 word/cycle.
- Ordering is strict FIFO. No word is dropped or duplicated absent flush.
- flush (synchronous, highest priority): OR.valid <= 0, SK.valid <= 0. A same-cycle accept is discarded and a same-cycle pop still counts downstream. in_ready = 1 the next cycle.
- Reset (Rst_n low, any time including mid-transfer): out_data=0, out_sel=0, out_valid=0, SK cleared, in_ready=1 immediately (asynchronous). No output activity until the first accept after deassert.
- out_data/out_sel are held stable while out_valid & !out_ready.
- Occupancy states: EMPTY (OR/SK invalid), ONE (OR valid), FULL (both valid).
  - EMPTY -accept-> ONE.
  - ONE -accept&!pop-> FULL.
  - ONE -pop&!accept-> EMPTY.
  - ONE -accept&pop-> ONE.
  - FULL -pop-> ONE.
  - Any -flush-> EMPTY.

Optional Feature:
- Macro MUX_N_TO_1_PIPE_SEL_CHECK_EN.
- Defined:
  - Adds output port sel_err (1 bit, reset 0).
  - sel_err sets sticky when an accept occurs with in_sel >= NUM_INPUTS.
  - It clears only on reset or flush.
  - The zero word is still forwarded.
- Undefined:
  - Port absent; out-of-range select silently yields zero.
  - No extra logic.

Decomposition:
- Shared package mux_pkg holds:
  - Function clog2_min1 (returns max(1,$clog2(n))), used for SEL_W.
  - Localparam encodings EMPTY=2'd0, ONE=2'd1, FULL=2'd2 for the occupancy state, used by the bench.
- One sub-module is natural: mux_n_to_1_comb (WIDTH, NUM_INPUTS), a pure combinational N-way selector with zero default. Instantiated once; the parent holds OR, SK and handshake logic.

Test Plan:
- Reset value check: assert Rst_n=0 mid-stream with OR and SK full -> out_valid=0, out_data=0, out_sel=0, in_ready=1 in the same cycle, before any clock edge.
- Basic select: NUM_INPUTS=4, WIDTH=32, inputs 0x11111111/0x22222222/0x33333333/0x44444444, out_ready=1, in_sel=2 with in_valid for 1 cycle -> next cycle out_data=0x33333333, out_sel=2, out_valid=1; the cycle after, out_valid=0.
- Backpressure: out_ready=0, accept sel=0 then sel=1 -> in_ready=0 after the 2nd accept, out_data holds 0x11111111. Raise out_ready -> 0x11111111 then 0x22222222 on consecutive cycles, in_ready=1 again.
- Full throughput: out_ready=1, in_valid=1 for 8 cycles, sel cycling 0..3 -> 8 outputs on 8 consecutive cycles in sel order 0,1,2,3,0,1,2,3.
- Out-of-range select: NUM_INPUTS=3, in_sel=3 accepted -> out_data=0, out_sel=3. With MUX_N_TO_1_PIPE_SEL_CHECK_EN, sel_err=1 and it stays 1 until flush.
- Flush in FULL state: OR and SK valid with out_ready=0, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed and same-cycle words never appear.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the pipelined N-way selector.
// Contents:
//   clog2_min1         select-width helper that never returns less than 1
//   EMPTY / ONE / FULL  occupancy encodings (output register / skid register)
package mux_pkg;

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   // Width of an index into n items.
   // The minimum of 1 keeps a 1-bit select when n <= 2.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mux_n_to_1_comb.sv
// Pure combinational N-way word selector.
// Ports:
//   in_data  flattened inputs; input k occupies [k*WIDTH +: WIDTH]
//   sel      index of the input to select
//   word     selected word, or all-zero when sel >= NUM_INPUTS
module mux_n_to_1_comb
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned NUM_INPUTS = 4,
   parameter int unsigned SEL_W      = clog2_min1(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]            sel,
   output logic [WIDTH-1:0]            word
);

   // Decoded OR-selection.
   // Out-of-range indices match no input, so word stays zero.
   always_comb begin
      word = '0;
      for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
         if (sel == SEL_W'(k)) begin
            word = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/mux_n_to_1_pipe.sv
// Registered N-way W-bit selector with a valid/ready handshake and a 1-entry skid buffer.
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_data/in_sel       flattened inputs and the index to capture
//   in_valid/in_ready    upstream handshake; in_ready is the inverse of skid-register occupancy
//   flush                synchronous discard of all held words (highest priority)
//   out_data/out_sel     registered selected word and the index that produced it
//   out_valid/out_ready  downstream handshake
//   sel_err              sticky out-of-range-select flag
//                        (only when MUX_N_TO_1_PIPE_SEL_CHECK_EN is defined)
module mux_n_to_1_pipe
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned NUM_INPUTS = 4,
   parameter int unsigned SEL_W      = clog2_min1(NUM_INPUTS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]            in_sel,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        flush,
`ifdef MUX_N_TO_1_PIPE_SEL_CHECK_EN
   output logic                        sel_err,
`endif
   output logic [WIDTH-1:0]            out_data,
   output logic [SEL_W-1:0]            out_sel,
   output logic                        out_valid,
   input  logic                        out_ready
);

   logic [WIDTH-1:0] word;

   // Output register (OR) and skid register (SK) state, plus next-state values.
   logic [WIDTH-1:0] or_data_n, sk_data, sk_data_n;
   logic [SEL_W-1:0] or_sel_n,  sk_sel,  sk_sel_n;
   logic             or_valid_n, sk_valid, sk_valid_n;
   logic             in_ready_n;
   logic             accept, pop;

   mux_n_to_1_comb #(
      .WIDTH      (WIDTH),
      .NUM_INPUTS (NUM_INPUTS),
      .SEL_W      (SEL_W)
   ) u_sel (
      .in_data (in_data),
      .sel     (in_sel),
      .word    (word)
   );

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   // Next-state logic for OR and SK.
   // An accept implies SK is empty, so a pop never has to move SK and
   // take a new word in the same cycle.
   always_comb begin
      or_data_n  = out_data;
      or_sel_n   = out_sel;
      or_valid_n = out_valid;
      sk_data_n  = sk_data;
      sk_sel_n   = sk_sel;
      sk_valid_n = sk_valid;

      if (flush) begin
         or_valid_n = 1'b0;
         sk_valid_n = 1'b0;
      end else begin
         if (pop) begin
            if (sk_valid) begin
               or_data_n  = sk_data;
               or_sel_n   = sk_sel;
               sk_valid_n = 1'b0;
            end else begin
               or_valid_n = 1'b0;
            end
         end
         if (accept) begin
            if (!out_valid || pop) begin
               or_data_n  = word;
               or_sel_n   = in_sel;
               or_valid_n = 1'b1;
            end else begin
               sk_data_n  = word;
               sk_sel_n   = in_sel;
               sk_valid_n = 1'b1;
            end
         end
      end

      // Registered copy of !SK.valid: no combinational path from out_ready.
      in_ready_n = !sk_valid_n;
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_sel   <= '0;
         out_valid <= 1'b0;
         sk_data   <= '0;
         sk_sel    <= '0;
         sk_valid  <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         out_data  <= or_data_n;
         out_sel   <= or_sel_n;
         out_valid <= or_valid_n;
         sk_data   <= sk_data_n;
         sk_sel    <= sk_sel_n;
         sk_valid  <= sk_valid_n;
         in_ready  <= in_ready_n;
      end
   end

`ifdef MUX_N_TO_1_PIPE_SEL_CHECK_EN
   // Widened by one bit so that NUM_INPUTS fits even when it is a power of two.
   localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_INPUTS);

   logic sel_err_n;

   // Sticky flag, set by an accepted out-of-range select.
   // Flush clears it and wins over a same-cycle set.
   always_comb begin
      sel_err_n = sel_err;
      if (flush) begin
         sel_err_n = 1'b0;
      end else if (accept && ({1'b0, in_sel} >= NUM_IN_W)) begin
         sel_err_n = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err <= 1'b0;
      end else begin
         sel_err <= sel_err_n;
      end
   end
`endif

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// Directed bench for mux_n_to_1_pipe.
// Instances:
//   dut4  WIDTH=32, NUM_INPUTS=4; table-driven handshake, backpressure, throughput and flush vectors
//   dut3  WIDTH=8,  NUM_INPUTS=3; out-of-range select handling
// Also covers asynchronous reset in the middle of a transfer.
// sel_err is checked when MUX_N_TO_1_PIPE_SEL_CHECK_EN is defined.
module tb_mux_n_to_1_pipe;
   import mux_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // dut4 signals
   logic [127:0] d4_in;
   logic [1:0]   d4_sel;
   logic         d4_valid, d4_ready, d4_flush;
   logic [31:0]  d4_odata;
   logic [1:0]   d4_osel;
   logic         d4_ovalid, d4_oready;

   // dut3 signals
   logic [23:0]  d3_in;
   logic [1:0]   d3_sel;
   logic         d3_valid, d3_ready, d3_flush;
   logic [7:0]   d3_odata;
   logic [1:0]   d3_osel;
   logic         d3_ovalid, d3_oready;

`ifdef MUX_N_TO_1_PIPE_SEL_CHECK_EN
   logic d4_err, d3_err;
`endif

   mux_n_to_1_pipe #(.WIDTH(32), .NUM_INPUTS(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (d4_in),
      .in_sel    (d4_sel),
      .in_valid  (d4_valid),
      .in_ready  (d4_ready),
      .flush     (d4_flush),
`ifdef MUX_N_TO_1_PIPE_SEL_CHECK_EN
      .sel_err   (d4_err),
`endif
      .out_data  (d4_odata),
      .out_sel   (d4_osel),
      .out_valid (d4_ovalid),
      .out_ready (d4_oready)
   );

   mux_n_to_1_pipe #(.WIDTH(8), .NUM_INPUTS(3)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (d3_in),
      .in_sel    (d3_sel),
      .in_valid  (d3_valid),
      .in_ready  (d3_ready),
      .flush     (d3_flush),
`ifdef MUX_N_TO_1_PIPE_SEL_CHECK_EN
      .sel_err   (d3_err),
`endif
      .out_data  (d3_odata),
      .out_sel   (d3_osel),
      .out_valid (d3_ovalid),
      .out_ready (d3_oready)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] occ4();
      if (!d4_ovalid) return EMPTY;
      return d4_ready ? ONE : FULL;
   endfunction

   // One vector: inputs applied for one clock edge, expectations sampled after it.
   typedef struct {
      logic        v;
      logic [1:0]  sel;
      logic        ordy;
      logic        fl;
      logic        ov;
      logic [31:0] od;
      logic [1:0]  os;
      logic [1:0]  occ;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic v, logic [1:0] sel, logic ordy, logic fl,
                               logic ov, logic [31:0] od, logic [1:0] os, logic [1:0] occ);
      vec_t r;
      r.v = v; r.sel = sel; r.ordy = ordy; r.fl = fl;
      r.ov = ov; r.od = od; r.os = os; r.occ = occ;
      return r;
   endfunction

   localparam logic [31:0] D0 = 32'h11111111;
   localparam logic [31:0] D1 = 32'h22222222;
   localparam logic [31:0] D2 = 32'h33333333;
   localparam logic [31:0] D3 = 32'h44444444;

   initial begin
      logic [31:0] dw[4];

      dw[0] = D0; dw[1] = D1; dw[2] = D2; dw[3] = D3;

      // Basic select
      vecs.push_back(mk(1, 2'd2, 1, 0,  1, D2, 2'd2, ONE));
      vecs.push_back(mk(0, 2'd0, 1, 0,  0, 0,  2'd0, EMPTY));
      // Backpressure: second accept lands in the skid register
      vecs.push_back(mk(1, 2'd0, 0, 0,  1, D0, 2'd0, ONE));
      vecs.push_back(mk(1, 2'd1, 0, 0,  1, D0, 2'd0, FULL));
      vecs.push_back(mk(0, 2'd0, 0, 0,  1, D0, 2'd0, FULL));
      vecs.push_back(mk(0, 2'd0, 1, 0,  1, D1, 2'd1, ONE));
      vecs.push_back(mk(0, 2'd0, 1, 0,  0, 0,  2'd0, EMPTY));
      // Full throughput, sel cycling 0..3 twice
      for (int k = 0; k < 8; k++)
         vecs.push_back(mk(1, 2'(k % 4), 1, 0,  1, dw[k % 4], 2'(k % 4), ONE));
      vecs.push_back(mk(0, 2'd0, 1, 0,  0, 0,  2'd0, EMPTY));
      // Flush in FULL with in_valid high
      vecs.push_back(mk(1, 2'd3, 0, 0,  1, D3, 2'd3, ONE));
      vecs.push_back(mk(1, 2'd0, 0, 0,  1, D3, 2'd3, FULL));
      vecs.push_back(mk(1, 2'd1, 0, 1,  0, 0,  2'd0, EMPTY));
      // Flush discards a same-cycle accept in ONE
      vecs.push_back(mk(1, 2'd2, 0, 0,  1, D2, 2'd2, ONE));
      vecs.push_back(mk(1, 2'd1, 0, 1,  0, 0,  2'd0, EMPTY));
      vecs.push_back(mk(0, 2'd0, 1, 0,  0, 0,  2'd0, EMPTY));
      vecs.push_back(mk(0, 2'd0, 1, 0,  0, 0,  2'd0, EMPTY));

      d4_in = {D3, D2, D1, D0};
      d4_sel = 0; d4_valid = 0; d4_flush = 0; d4_oready = 0;
      d3_in = {8'hC3, 8'hB2, 8'hA1};
      d3_sel = 0; d3_valid = 0; d3_flush = 0; d3_oready = 1;

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(d4_ovalid), 0);
      chk("rst_out_data", d4_odata, 0);
      chk("rst_in_ready", 32'(d4_ready), 1);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors on dut4
      foreach (vecs[i]) begin
         d4_valid  = vecs[i].v;
         d4_sel    = vecs[i].sel;
         d4_oready = vecs[i].ordy;
         d4_flush  = vecs[i].fl;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("v%0d_out_valid", i), 32'(d4_ovalid), 32'(vecs[i].ov));
         if (vecs[i].ov) begin
            chk($sformatf("v%0d_out_data", i), d4_odata, vecs[i].od);
            chk($sformatf("v%0d_out_sel", i), 32'(d4_osel), 32'(vecs[i].os));
         end
         chk($sformatf("v%0d_occupancy", i), 32'(occ4()), 32'(vecs[i].occ));
      end
      d4_valid = 0; d4_flush = 0;

      // Out-of-range select on the 3-input instance
      d3_valid = 1; d3_sel = 2'd1;
      @(posedge clk); @(negedge clk);
      chk("oor_inrange_data", 32'(d3_odata), 32'h0B2);
      chk("oor_inrange_sel", 32'(d3_osel), 1);
`ifdef MUX_N_TO_1_PIPE_SEL_CHECK_EN
      chk("oor_err_before", 32'(d3_err), 0);
`endif
      d3_sel = 2'd3;
      @(posedge clk); @(negedge clk);
      chk("oor_valid", 32'(d3_ovalid), 1);
      chk("oor_data_zero", 32'(d3_odata), 0);
      chk("oor_sel", 32'(d3_osel), 3);
      d3_valid = 0;
      repeat (2) begin
         @(posedge clk); @(negedge clk);
`ifdef MUX_N_TO_1_PIPE_SEL_CHECK_EN
         chk("oor_err_sticky", 32'(d3_err), 1);
`endif
         chk("oor_drained", 32'(d3_ovalid), 0);
      end
      d3_flush = 1;
      @(posedge clk); @(negedge clk);
      d3_flush = 0;
`ifdef MUX_N_TO_1_PIPE_SEL_CHECK_EN
      chk("oor_err_flushed", 32'(d3_err), 0);
      chk("in_range_no_err", 32'(d4_err), 0);
`endif
      chk("oor_after_flush_ready", 32'(d3_ready), 1);

      // Asynchronous reset with OR and SK full
      d4_oready = 0; d4_valid = 1; d4_sel = 2'd2;
      @(posedge clk); @(negedge clk);
      d4_sel = 2'd3;
      @(posedge clk); @(negedge clk);
      d4_valid = 0;
      chk("pre_rst_occupancy", 32'(occ4()), 32'(FULL));
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(d4_ovalid), 0);
      chk("async_rst_out_data", d4_odata, 0);
      chk("async_rst_out_sel", 32'(d4_osel), 0);
      chk("async_rst_in_ready", 32'(d4_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      d4_oready = 1;
      repeat (2) @(negedge clk);
      chk("post_rst_quiet", 32'(d4_ovalid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
